// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame constants, FSM state type and the
// ASCII-to-set-2 make-code table used by both the transmitter and the decoder.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK      = 8'hF0;
    localparam int         PS2_FRAME_BITS = 11;

    typedef struct packed {
        logic       valid;
        logic [7:0] code;
    } scan_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP
    } kbd_state_t;

    // Lower-case letters fold onto their upper-case keys; anything outside
    // A-Z, a-z and 0-9 comes back with valid = 0.
    function automatic scan_t ascii_to_scan(input logic [7:0] ascii);
        logic [7:0] key;
        scan_t      res;
        key = (ascii >= 8'h61 && ascii <= 8'h7A) ? ascii - 8'h20 : ascii;
        res = '{valid: 1'b1, code: 8'h00};
        case (key)
            8'h41: res.code = 8'h1C;  8'h42: res.code = 8'h32;
            8'h43: res.code = 8'h21;  8'h44: res.code = 8'h23;
            8'h45: res.code = 8'h24;  8'h46: res.code = 8'h2B;
            8'h47: res.code = 8'h34;  8'h48: res.code = 8'h33;
            8'h49: res.code = 8'h43;  8'h4A: res.code = 8'h3B;
            8'h4B: res.code = 8'h42;  8'h4C: res.code = 8'h4B;
            8'h4D: res.code = 8'h3A;  8'h4E: res.code = 8'h31;
            8'h4F: res.code = 8'h44;  8'h50: res.code = 8'h4D;
            8'h51: res.code = 8'h15;  8'h52: res.code = 8'h2D;
            8'h53: res.code = 8'h1B;  8'h54: res.code = 8'h2C;
            8'h55: res.code = 8'h3C;  8'h56: res.code = 8'h2A;
            8'h57: res.code = 8'h1D;  8'h58: res.code = 8'h22;
            8'h59: res.code = 8'h35;  8'h5A: res.code = 8'h1A;
            8'h30: res.code = 8'h45;  8'h31: res.code = 8'h16;
            8'h32: res.code = 8'h1E;  8'h33: res.code = 8'h26;
            8'h34: res.code = 8'h25;  8'h35: res.code = 8'h2E;
            8'h36: res.code = 8'h36;  8'h37: res.code = 8'h3D;
            8'h38: res.code = 8'h3E;  8'h39: res.code = 8'h46;
            default: res.valid = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ps2_frame_tx.sv
// Serializes one byte as an 11-bit PS/2 device-to-host frame. The bit
// sequencer runs one cycle ahead of the registered line outputs, so `done`
// fires in the last sequencer cycle while the lines show the stop bit's low
// half for one more cycle.
module ps2_frame_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV = 4
)
(
    input  logic       clk,
    input  logic       clrn,
    input  logic       start,
    input  logic [7:0] data,
    output logic       done,
    output logic       ps2_clk,
    output logic       ps2_data
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic                      active;
    logic                      low_half;
    logic [DW-1:0]             div_cnt;
    logic [3:0]                bit_cnt;
    logic [PS2_FRAME_BITS-1:0] shreg;
    logic                      line_clk;
    logic                      line_data;
    logic                      half_end;

    assign half_end  = (div_cnt == DW'(CLK_DIV - 1));
    assign line_clk  = !(active && low_half);
    assign line_data = active ? shreg[0] : 1'b1;
    assign done      = active && low_half && half_end
                       && (bit_cnt == 4'(PS2_FRAME_BITS - 1));

    // Bit sequencer plus output registers; a reset drops any partial frame
    // and returns both lines high on the same edge.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            active   <= 1'b0;
            low_half <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '1;
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
        end else begin
            ps2_clk  <= line_clk;
            ps2_data <= line_data;
            if (start) begin
                // stop, odd parity, data LSB-first, start
                active   <= 1'b1;
                low_half <= 1'b0;
                div_cnt  <= '0;
                bit_cnt  <= '0;
                shreg    <= {1'b1, ~^data, data, 1'b0};
            end else if (active) begin
                if (half_end) begin
                    div_cnt <= '0;
                    if (!low_half) begin
                        low_half <= 1'b1;
                    end else begin
                        low_half <= 1'b0;
                        shreg    <= {1'b1, shreg[PS2_FRAME_BITS-1:1]};
                        if (bit_cnt == 4'(PS2_FRAME_BITS - 1))
                            active <= 1'b0;
                        else
                            bit_cnt <= bit_cnt + 4'd1;
                    end
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ascii_ps2_kbd.sv
// PS/2 keyboard emulator: accepts ASCII characters and types each one as a
// full keystroke (make, F0, make) of device-to-host frames.
module ascii_ps2_kbd
    import ps2_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int GAP     = 8
)
(
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] ascii_in,
    input  logic       ascii_valid,
    output logic       ascii_ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       bad_char
);

    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    kbd_state_t  state;
    logic [1:0]  byte_idx;
    logic [7:0]  code;
    logic [GW-1:0] gap_cnt;
    scan_t       scan;
    logic [7:0]  tx_byte;
    logic        tx_start;
    logic        tx_done;

    assign scan     = ascii_to_scan(ascii_in);
    assign tx_byte  = (byte_idx == 2'd1) ? PS2_BREAK : code;
    assign tx_start = (state == ST_LOAD);

    ps2_frame_tx #(.CLK_DIV(CLK_DIV)) u_tx (
        .clk      (clk),
        .clrn     (clrn),
        .start    (tx_start),
        .data     (tx_byte),
        .done     (tx_done),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data)
    );

    // Character FSM: accept, sequence three frames with gaps, and keep the
    // handshake and status outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state       <= ST_IDLE;
            byte_idx    <= '0;
            code        <= '0;
            gap_cnt     <= '0;
            ascii_ready <= 1'b1;
            busy        <= 1'b0;
            bad_char    <= 1'b0;
        end else begin
            bad_char <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ascii_valid && ascii_ready) begin
                        if (scan.valid) begin
                            code        <= scan.code;
                            byte_idx    <= '0;
                            state       <= ST_LOAD;
                            ascii_ready <= 1'b0;
                            busy        <= 1'b1;
                        end else begin
                            bad_char <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (tx_done) begin
                        state   <= ST_GAP;
                        gap_cnt <= GW'(GAP - 1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        if (byte_idx == 2'd2) begin
                            state       <= ST_IDLE;
                            ascii_ready <= 1'b1;
                            busy        <= 1'b0;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            state    <= ST_LOAD;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_ps2_kbd.sv
// Self-checking bench for ascii_ps2_kbd: a PS/2 line receiver decodes the
// emitted frames, and keystrokes are compared against a table lookup model.
module tb_ascii_ps2_kbd;

    localparam int CLK_DIV = 4;
    localparam int GAP     = 8;
    localparam int KEY_LEN = 3 * (22 * CLK_DIV + GAP + 1);   // 291
    localparam int NV      = 13;

    logic       clk;
    logic       clrn;
    logic [7:0] ascii_in;
    logic       ascii_valid;
    logic       ascii_ready;
    logic       ps2_clk;
    logic       ps2_data;
    logic       busy;
    logic       bad_char;

    ascii_ps2_kbd #(.CLK_DIV(CLK_DIV), .GAP(GAP)) dut (
        .clk         (clk),
        .clrn        (clrn),
        .ascii_in    (ascii_in),
        .ascii_valid (ascii_valid),
        .ascii_ready (ascii_ready),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .busy        (busy),
        .bad_char    (bad_char)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkb(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Reference model: keyboard layout as plain lookup arrays.
    logic [7:0] letters [0:25] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                   8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                   8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                   8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digits [0:9]   = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                   8'h3D, 8'h3E, 8'h46};

    task automatic ref_map(input logic [7:0] ch, output bit ok, output logic [7:0] code);
        ok = 1'b0;
        code = 8'h00;
        for (int i = 0; i < 26; i++)
            if (ch == 8'(8'h41 + i) || ch == 8'(8'h61 + i)) begin
                ok = 1'b1;
                code = letters[5'(i)];
            end
        for (int i = 0; i < 10; i++)
            if (ch == 8'(8'h30 + i)) begin
                ok = 1'b1;
                code = digits[4'(i)];
            end
    endtask

    // Reverse lookup standing in for the receive-side decoder.
    function automatic logic [7:0] rev_map(input logic [7:0] code);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 26; i++) if (letters[5'(i)] == code) r = 8'(8'h41 + i);
        for (int i = 0; i < 10; i++) if (digits[4'(i)] == code) r = 8'(8'h30 + i);
        return r;
    endfunction

    // Line receiver: sample data on each falling ps2_clk, check framing.
    logic [7:0]  rx_q [$];
    logic [10:0] fr = '0;
    logic        prev_clk = 1'b1;
    int          bit_n = 0;
    int          clk_trans = 0;
    int          busy_cycles = 0;
    int          bad_pulses = 0;

    always @(negedge clk) begin
        if (!clrn) begin
            bit_n = 0;
        end else if (prev_clk === 1'b1 && ps2_clk === 1'b0) begin
            fr = {ps2_data, fr[10:1]};
            bit_n++;
            if (bit_n == 11) begin
                checkb("frame_start", fr[0], 1'b0);
                checkb("frame_stop", fr[10], 1'b1);
                checkb("frame_parity_odd", ^fr[9:1], 1'b1);
                rx_q.push_back(fr[8:1]);
                bit_n = 0;
            end
        end
        if (ps2_clk !== prev_clk) clk_trans++;
        if (busy === 1'b1) busy_cycles++;
        if (bad_char === 1'b1) bad_pulses++;
        prev_clk = ps2_clk;
    end

    // Returns on the falling edge right after the accepting rising edge.
    task automatic send_char(input logic [7:0] ch);
        int n = 0;
        while (ascii_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkb("ready_before_send", ascii_ready, 1'b1);
        ascii_in = ch;
        ascii_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ascii_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkb("idle_timeout", busy, 1'b0);
    endtask

    task automatic keystroke(input logic [7:0] ch, input bit ok, input logic [7:0] code, input string tag);
        int base, bad0, tr0, busy0;
        logic [7:0] exp [0:2];
        base = rx_q.size();
        bad0 = bad_pulses;
        tr0 = clk_trans;
        busy0 = busy_cycles;
        exp = '{code, 8'hF0, code};
        send_char(ch);
        if (ok) begin
            wait_idle();
            check({tag, "_busy_len"}, busy_cycles - busy0, KEY_LEN);
            check({tag, "_nbytes"}, rx_q.size() - base, 3);
            if (rx_q.size() >= base + 3)
                for (int i = 0; i < 3; i++)
                    check({tag, "_byte"}, {24'h0, rx_q[base + i]}, {24'h0, exp[2'(i)]});
            check({tag, "_no_bad"}, bad_pulses - bad0, 0);
        end else begin
            checkb({tag, "_bad_pulse"}, bad_char, 1'b1);
            checkb({tag, "_ready_hold"}, ascii_ready, 1'b1);
            @(negedge clk);
            checkb({tag, "_bad_end"}, bad_char, 1'b0);
            repeat (20) @(negedge clk);
            check({tag, "_bad_count"}, bad_pulses - bad0, 1);
            check({tag, "_no_clk"}, clk_trans - tr0, 0);
            check({tag, "_no_busy"}, busy_cycles - busy0, 0);
            checkb({tag, "_ready_after"}, ascii_ready, 1'b1);
        end
    endtask

    typedef struct {
        logic [7:0] ch;
        bit         ok;
        logic [7:0] code;
    } vec_t;

    vec_t vecs [0:NV-1];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         base, busy0, n;
        bit         ok;
        logic [7:0] code, ch;
        int         r;
        logic [1:0] exp_clk  [0:6];

        vecs = '{'{8'h7A, 1'b1, 8'h1A}, '{8'h5A, 1'b1, 8'h1A}, '{8'h30, 1'b1, 8'h45},
                 '{8'h39, 1'b1, 8'h46}, '{8'h51, 1'b1, 8'h15}, '{8'h6D, 1'b1, 8'h3A},
                 '{8'h23, 1'b0, 8'h00}, '{8'h40, 1'b0, 8'h00}, '{8'h5B, 1'b0, 8'h00},
                 '{8'h60, 1'b0, 8'h00}, '{8'h7B, 1'b0, 8'h00}, '{8'h2F, 1'b0, 8'h00},
                 '{8'h3A, 1'b0, 8'h00}};

        clrn = 1'b0;
        ascii_valid = 1'b0;
        ascii_in = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkb("rst_ps2_clk", ps2_clk, 1'b1);
        checkb("rst_ps2_data", ps2_data, 1'b1);
        checkb("rst_ready", ascii_ready, 1'b1);
        checkb("rst_busy", busy, 1'b0);
        checkb("rst_bad", bad_char, 1'b0);
        clrn = 1'b1;
        repeat (2) @(negedge clk);

        // 'A' with start-of-keystroke latency: {ps2_clk, ps2_data} per cycle after accept
        exp_clk = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
        base = rx_q.size();
        busy0 = busy_cycles;
        send_char(8'h41);
        checkb("lat_busy", busy, 1'b1);
        checkb("lat_ready_low", ascii_ready, 1'b0);
        for (int k = 0; k < 7; k++) begin
            check("lat_lines", {30'h0, ps2_clk, ps2_data}, {30'h0, exp_clk[3'(k)]});
            if (k < 6) @(negedge clk);
        end
        wait_idle();
        check("A_busy_len", busy_cycles - busy0, KEY_LEN);
        check("A_nbytes", rx_q.size() - base, 3);
        if (rx_q.size() >= base + 3) begin
            check("A_b0", {24'h0, rx_q[base]}, 32'h1C);
            check("A_b1", {24'h0, rx_q[base + 1]}, 32'hF0);
            check("A_b2", {24'h0, rx_q[base + 2]}, 32'h1C);
        end

        for (int i = 0; i < NV; i++)
            keystroke(vecs[4'(i)].ch, vecs[4'(i)].ok, vecs[4'(i)].code, "vec");

        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) begin
                r = int'($urandom_range(0, 61));
                ch = (r < 10) ? 8'(8'h30 + r) : (r < 36) ? 8'(8'h41 + r - 10) : 8'(8'h61 + r - 36);
            end else begin
                ch = 8'($urandom_range(32, 126));
            end
            ref_map(ch, ok, code);
            keystroke(ch, ok, code, "rand");
        end

        // '1' then '2' with ascii_valid held high throughout
        base = rx_q.size();
        busy0 = busy_cycles;
        @(negedge clk);
        ascii_in = 8'h31;
        ascii_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ascii_in = 8'h32;
        n = 0;
        while (ascii_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("b2b_holdoff", n, KEY_LEN);
        @(posedge clk);
        @(negedge clk);
        ascii_valid = 1'b0;
        checkb("b2b_second_accept", busy, 1'b1);
        wait_idle();
        check("b2b_busy_len", busy_cycles - busy0, 2 * KEY_LEN);
        check("b2b_nbytes", rx_q.size() - base, 6);
        if (rx_q.size() >= base + 6) begin
            check("b2b_b0", {24'h0, rx_q[base]}, 32'h16);
            check("b2b_b1", {24'h0, rx_q[base + 1]}, 32'hF0);
            check("b2b_b2", {24'h0, rx_q[base + 2]}, 32'h16);
            check("b2b_b3", {24'h0, rx_q[base + 3]}, 32'h1E);
            check("b2b_b4", {24'h0, rx_q[base + 4]}, 32'hF0);
            check("b2b_b5", {24'h0, rx_q[base + 5]}, 32'h1E);
            check("loop_char0", {24'h0, rev_map(rx_q[base])}, 32'h31);
            check("loop_char1", {24'h0, rev_map(rx_q[base + 3])}, 32'h32);
        end

        // Reset during the data bits of the second frame
        base = rx_q.size();
        send_char(8'h31);
        repeat (130) @(negedge clk);
        clrn = 1'b0;
        @(negedge clk);
        checkb("mid_rst_clk", ps2_clk, 1'b1);
        checkb("mid_rst_data", ps2_data, 1'b1);
        checkb("mid_rst_ready", ascii_ready, 1'b1);
        checkb("mid_rst_busy", busy, 1'b0);
        clrn = 1'b1;
        @(negedge clk);
        check("mid_rst_nbytes", rx_q.size() - base, 1);
        if (rx_q.size() >= base + 1)
            check("mid_rst_b0", {24'h0, rx_q[base]}, 32'h16);
        keystroke(8'h45, 1'b1, 8'h24, "after_rst_E");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
